// File: rtl/fft_pkg.sv
// fft_pkg: shared widths, complex sample type and Q1.15 rounding/saturation helpers
package fft_pkg;
  localparam int DW = 16;
  localparam int TW_FRAC = 15;
  localparam int PW = 2*DW+1;
  localparam int TRW = PW-TW_FRAC;
  localparam int SW = DW+3;
  typedef struct packed {
    logic signed [DW-1:0] re;
    logic signed [DW-1:0] im;
  } cplx_t;
  typedef struct packed {
    logic ovf;
    logic signed [DW-1:0] val;
  } sat_t;
  function automatic sat_t sat_dw(input logic signed [SW-1:0] v);
    sat_t r;
    r.ovf = !(&v[SW-1:DW-1] || ~|v[SW-1:DW-1]);
    r.val = r.ovf ? {v[SW-1], {(DW-1){~v[SW-1]}}} : v[DW-1:0];
    return r;
  endfunction
  // round half up, then drop the twiddle fraction bits
  function automatic logic signed [TRW-1:0] round_shift(input logic signed [PW-1:0] p);
    logic signed [PW-1:0] s;
    s = p + $signed(PW'(1) << (TW_FRAC-1));
    return s[PW-1:TW_FRAC];
  endfunction
endpackage

// File: rtl/cmul_q15.sv
// cmul_q15: registered Q1.15 complex product B*W, combined and rounded back to DW+2 bits
module cmul_q15
  import fft_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en,
  input  cplx_t                 b,
  input  cplx_t                 w,
  output logic signed [TRW-1:0] t_re,
  output logic signed [TRW-1:0] t_im
);
  logic signed [2*DW-1:0] rr, ii, ri, ir;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      rr <= '0;
      ii <= '0;
      ri <= '0;
      ir <= '0;
    end else if (en) begin
      rr <= b.re * w.re;
      ii <= b.im * w.im;
      ri <= b.re * w.im;
      ir <= b.im * w.re;
    end
  assign t_re = round_shift($signed({rr[2*DW-1], rr}) - $signed({ii[2*DW-1], ii}));
  assign t_im = round_shift($signed({ri[2*DW-1], ri}) + $signed({ir[2*DW-1], ir}));
endmodule

// File: rtl/fft_bfly_pipe.sv
// fft_bfly_pipe: 3-stage radix-2 DIT butterfly X = A + B*W, Y = A - B*W with
// optional halving, rounding, saturation and full valid/ready backpressure
module fft_bfly_pipe
  import fft_pkg::*;
#(
  parameter bit SCALE = 1'b1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic signed [DW-1:0] a_re,
  input  logic signed [DW-1:0] a_im,
  input  logic signed [DW-1:0] b_re,
  input  logic signed [DW-1:0] b_im,
  input  logic signed [DW-1:0] tw_re,
  input  logic signed [DW-1:0] tw_im,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic signed [DW-1:0] x_re,
  output logic signed [DW-1:0] x_im,
  output logic signed [DW-1:0] y_re,
  output logic signed [DW-1:0] y_im,
  output logic                 ovf,
  input  logic                 ovf_clr
);
  localparam logic signed [SW-1:0] ONE = 1;
  cplx_t a1, b1, w1, a2;
  logic v1, v2, v3, en1, en2, en3, sat_any;
  logic signed [TRW-1:0] t_re, t_im;
  logic signed [SW-1:0] ar, ai, tr, ti;
  sat_t sxr, sxi, syr, syi;
  assign en3 = out_ready | ~v3;
  assign en2 = en3 | ~v2;
  assign en1 = en2 | ~v1;
  assign in_ready = en1;
  assign out_valid = v3;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      v1 <= 1'b0;
      a1 <= '0;
      b1 <= '0;
      w1 <= '0;
    end else if (en1) begin
      v1 <= in_valid;
      a1 <= '{a_re, a_im};
      b1 <= '{b_re, b_im};
      w1 <= '{tw_re, tw_im};
    end
  cmul_q15 u_cmul (
    .clk  (clk),
    .rst_n(rst_n),
    .en   (en2),
    .b    (b1),
    .w    (w1),
    .t_re (t_re),
    .t_im (t_im)
  );
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      v2 <= 1'b0;
      a2 <= '0;
    end else if (en2) begin
      v2 <= v1;
      a2 <= a1;
    end
  function automatic logic signed [SW-1:0] scl(input logic signed [SW-1:0] v);
    return SCALE ? (v + ONE) >>> 1 : v;
  endfunction
  assign ar = SW'(a2.re);
  assign ai = SW'(a2.im);
  assign tr = SW'(t_re);
  assign ti = SW'(t_im);
  always_comb begin
    sxr = sat_dw(scl(ar + tr));
    sxi = sat_dw(scl(ai + ti));
    syr = sat_dw(scl(ar - tr));
    syi = sat_dw(scl(ai - ti));
    sat_any = sxr.ovf | sxi.ovf | syr.ovf | syi.ovf;
  end
  // output data only reloads on a real beat so it stays put across bubbles
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      v3 <= 1'b0;
      x_re <= '0;
      x_im <= '0;
      y_re <= '0;
      y_im <= '0;
      ovf <= 1'b0;
    end else begin
      if (en3) v3 <= v2;
      if (en3 && v2) begin
        x_re <= sxr.val;
        x_im <= sxi.val;
        y_re <= syr.val;
        y_im <= syi.val;
      end
      ovf <= (en3 && v2 && sat_any) ? 1'b1 : ovf & ~ovf_clr;
    end
endmodule
